magic_arbiter: RTL and testbench
================================

MAGIC_ARBITER -- requirements
Module: magic_arbiter

Interface
REQ-001: Parameter TIMEOUT_CYCLES, default 1023, meaning the maximum WAIT-state cycles before a job is aborted (legal range 2..1023).
REQ-002: i_clk  input  1  clock; all state changes on the rising edge.
REQ-003: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004: i_req  input  2  per-requester classification request (level).
REQ-005: i_canvas0  input  900  requester 0 bitmap, 30x30, bit index y*30+x.
REQ-006: i_canvas1  input  900  requester 1 bitmap, same layout.
REQ-007: o_grant  output  2  one-hot owner of the engine; 0 when idle.
REQ-008: o_eng_start_n  output  1  active-low start pulse to the classifier engine's button input.
REQ-009: o_eng_canvas  output  900  registered canvas snapshot driven to the engine.
REQ-010: i_eng_digit  input  4  engine result digit.
REQ-011: i_eng_valid  input  1  engine result strobe, one cycle.
REQ-012: o_done  output  2  one-cycle completion pulse to the granted requester.
REQ-013: o_digit  output  4  result of the most recent job, held until the next DONE.
REQ-014: o_timeout  output  1  one-cycle pulse, coincident with o_done, when the job was aborted.
REQ-015: o_busy  output  1  high whenever state is not IDLE.

Function
REQ-016: The block SHALL implement states IDLE, START, WAIT and DONE.
REQ-017: IDLE: if i_req is nonzero, next edge -> START, load o_grant, snapshot the granted canvas into o_eng_canvas, and update the last-served pointer; otherwise remain IDLE.
REQ-018: Arbitration: a single request is granted directly; if both bits are set, grant the requester not served last (round-robin).
REQ-019: START lasts exactly one cycle with o_eng_start_n=0; next edge -> WAIT with the timeout counter cleared to 0.
REQ-020: o_eng_start_n SHALL be 1 in every state other than START.
REQ-021: WAIT: the counter increments each cycle; on i_eng_valid=1, latch i_eng_digit into o_digit and go -> DONE.
REQ-022: WAIT: if counter==TIMEOUT_CYCLES-1 and i_eng_valid=0, set o_digit=4'hF, set the timeout flag, and go -> DONE.
REQ-023: If i_eng_valid and the timeout condition occur in the same cycle, the valid result wins and o_timeout stays 0.
REQ-024: i_eng_valid outside WAIT SHALL be ignored (no state change, o_digit unchanged).
REQ-025: DONE lasts one cycle: o_done = o_grant, o_timeout = the timeout flag; next edge -> IDLE, o_grant cleared to 0.
REQ-026: o_eng_canvas SHALL remain stable from START through DONE regardless of canvas input changes.
REQ-027: i_req is sampled only in IDLE; deasserting a request mid-job SHALL NOT abort the job, and o_done still pulses.
REQ-028: At least one IDLE cycle SHALL separate consecutive jobs; a request held high through DONE is re-arbitrated in that IDLE cycle.
REQ-029: Counter width SHALL be 10 bits; the counter SHALL NOT wrap within a job.

Reset
REQ-030: Asserting i_rst_n low at any time SHALL immediately force: state IDLE, o_grant=0, o_eng_start_n=1, o_eng_canvas=0, o_done=0, o_digit=0, o_timeout=0, o_busy=0, counter=0, and last-served pointer=1 (requester 0 wins the first tie).
REQ-031: Reset mid-job SHALL discard the job without an o_done pulse; after release, operation resumes from IDLE.

Verification
REQ-032: i_req=01, engine model returns digit 7 with valid 901 cycles after the start edge -> grant=01, exactly one start_n low cycle, o_done=01 for one cycle, o_digit=7, o_timeout=0.
REQ-033: i_req=11 held through three jobs from reset -> grant sequence 01, 10, 01, with o_done pulses matching each grant.
REQ-034: TIMEOUT_CYCLES=16, engine never asserts valid -> DONE exactly 16 cycles after entering WAIT, o_digit=F, o_timeout=1, o_done=grant.
REQ-035: Valid asserted on the final timeout cycle (TIMEOUT_CYCLES=16) with digit 3 -> o_digit=3, o_timeout=0.
REQ-036: i_canvas0 toggled every cycle during WAIT, and i_eng_valid pulsed while IDLE -> o_eng_canvas equals the START snapshot, and the spurious valid causes no state or o_digit change.
REQ-037: i_rst_n pulsed low mid-WAIT -> all outputs at reset values asynchronously, no o_done; a fresh i_req=10 afterward completes normally.

Source files
------------

// File: rtl/magic_arbiter.sv
// magic_arbiter: round-robin sharing of one digit-classifier engine between two canvas requesters, with a per-job timeout.
module magic_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [1:0]   i_req,
    input  logic [899:0] i_canvas0,
    input  logic [899:0] i_canvas1,
    output logic [1:0]   o_grant,
    output logic         o_eng_start_n,
    output logic [899:0] o_eng_canvas,
    input  logic [3:0]   i_eng_digit,
    input  logic         i_eng_valid,
    output logic [1:0]   o_done,
    output logic [3:0]   o_digit,
    output logic         o_timeout,
    output logic         o_busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [1:0]   state_q, state_d;
    logic [1:0]   grant_q, grant_d;
    logic         last_q, last_d;
    logic [899:0] canvas_q, canvas_d;
    logic [9:0]   cnt_q, cnt_d;
    logic [3:0]   digit_q, digit_d;
    logic         tflag_q, tflag_d;
    logic         pick;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        canvas_d = canvas_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        tflag_d  = tflag_q;
        // on a tie, serve whoever was not served last
        pick = (i_req == 2'b11) ? ~last_q : i_req[1];
        case (state_q)
            IDLE: if (|i_req) begin
                state_d  = START;
                grant_d  = pick ? 2'b10 : 2'b01;
                last_d   = pick;
                canvas_d = pick ? i_canvas1 : i_canvas0;
                tflag_d  = 1'b0;
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: if (i_eng_valid) begin
                digit_d = i_eng_digit;
                state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
                digit_d = 4'hF;
                tflag_d = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + 10'd1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= 1'b1;
            canvas_q <= '0;
            cnt_q    <= '0;
            digit_q  <= '0;
            tflag_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            canvas_q <= canvas_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            tflag_q  <= tflag_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_eng_start_n = (state_q != START);
    assign o_eng_canvas  = canvas_q;
    assign o_done        = (state_q == DONE) ? grant_q : 2'b00;
    assign o_digit       = digit_q;
    assign o_timeout     = (state_q == DONE) & tflag_q;
    assign o_busy        = (state_q != IDLE);
endmodule

// File: tb/tb_magic_arbiter.sv
// tb_magic_arbiter: two arbiter instances (default timeout and timeout 16) checked every cycle against a timestamp-based job model.
module tb_magic_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0][1:0]   req, grant, done;
    logic [1:0][899:0] cv0, cv1, ecv;
    logic [1:0][3:0]   edig, digit;
    logic [1:0]        evld, start_n, tmo, busy;

    always #5 clk = ~clk;

    magic_arbiter u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_canvas0(cv0[0]), .i_canvas1(cv1[0]),
        .o_grant(grant[0]), .o_eng_start_n(start_n[0]), .o_eng_canvas(ecv[0]),
        .i_eng_digit(edig[0]), .i_eng_valid(evld[0]), .o_done(done[0]), .o_digit(digit[0]),
        .o_timeout(tmo[0]), .o_busy(busy[0])
    );

    magic_arbiter #(.TIMEOUT_CYCLES(16)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_canvas0(cv0[1]), .i_canvas1(cv1[1]),
        .o_grant(grant[1]), .o_eng_start_n(start_n[1]), .o_eng_canvas(ecv[1]),
        .i_eng_digit(edig[1]), .i_eng_valid(evld[1]), .o_done(done[1]), .o_digit(digit[1]),
        .o_timeout(tmo[1]), .o_busy(busy[1])
    );

    // model: a job is a grant, its START cycle number and its DONE cycle number
    bit           m_act [2];
    logic [1:0]   m_g   [2];
    int           m_t0  [2];
    int           m_done[2];
    bit           m_to  [2];
    logic [3:0]   m_dig [2];
    logic [899:0] m_cv  [2];
    bit           m_last[2];
    int cyc = 0;
    int passed = 0;
    int total = 0;
    int nstart[2];
    int ndone[2];
    int t_start[2];
    int t_done[2];
    logic [1:0] gseq[$];
    logic [1:0] exp_seq[3] = '{2'b01, 2'b10, 2'b01};

    function automatic int tmax(int k);
        return (k == 0) ? 1023 : 16;
    endfunction

    task automatic chk(string nm, int k, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s[%0d] cyc %0d: got %0h expected %0h", nm, k, cyc, got, exp);
    endtask

    task automatic chk_cv(string nm, int k, logic [899:0] got, logic [899:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s[%0d] cyc %0d: got low64 %0h expected low64 %0h", nm, k, cyc, got[63:0], exp[63:0]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_g[k] = 2'b00; m_t0[k] = -10; m_done[k] = -1;
            m_to[k] = 0; m_dig[k] = 4'h0; m_cv[k] = '0; m_last[k] = 1;
        end
    endtask

    task automatic model_edge(int k);
        int e;
        logic idx;
        e = cyc;
        if (!m_act[k]) begin
            if (req[k] != 2'b00) begin
                idx = (req[k] == 2'b11) ? !m_last[k] : req[k][1];
                m_act[k] = 1; m_g[k] = idx ? 2'b10 : 2'b01; m_last[k] = idx;
                m_t0[k] = e + 1; m_done[k] = -1; m_cv[k] = idx ? cv1[k] : cv0[k];
            end
        end else if (e == m_done[k]) begin
            m_act[k] = 0; m_g[k] = 2'b00;
        end else if (m_done[k] < 0 && e > m_t0[k]) begin
            if (evld[k]) begin
                m_dig[k] = edig[k]; m_to[k] = 0; m_done[k] = e + 1;
            end else if (e - (m_t0[k] + 1) == tmax(k) - 1) begin
                m_dig[k] = 4'hF; m_to[k] = 1; m_done[k] = e + 1;
            end
        end
    endtask

    task automatic compare();
        logic [1:0] ed;
        for (int k = 0; k < 2; k++) begin
            ed = (m_act[k] && cyc == m_done[k]) ? m_g[k] : 2'b00;
            chk("grant", k, grant[k], m_g[k]);
            chk("start_n", k, start_n[k], !(m_act[k] && cyc == m_t0[k]));
            chk("done", k, done[k], ed);
            chk("timeout", k, tmo[k], (ed != 2'b00) && m_to[k]);
            chk("digit", k, digit[k], m_dig[k]);
            chk("busy", k, busy[k], m_act[k]);
            chk_cv("canvas", k, ecv[k], m_cv[k]);
            if (!start_n[k]) begin nstart[k]++; t_start[k] = cyc; end
            if (done[k] != 2'b00) begin
                ndone[k]++; t_done[k] = cyc;
                if (k == 1) gseq.push_back(done[1]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else for (int k = 0; k < 2; k++) model_edge(k);
        cyc++;
        #1;
        compare();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [899:0] snap;
        int nd;
        int n;
        req = '0; cv0 = '0; cv1 = '0; edig = '0; evld = '0;
        for (int k = 0; k < 2; k++) begin nstart[k] = 0; ndone[k] = 0; t_start[k] = 0; t_done[k] = 0; end
        model_reset();
        #1;
        compare();
        step();
        step();
        rst_n = 1'b1;

        // single request, result after 901 cycles
        cv0[0] = {30{30'h2AAA5555}};
        req[0] = 2'b01;
        step();
        chk("t1_start_n", 0, start_n[0], 1'b0);
        chk("t1_grant", 0, grant[0], 2'b01);
        req[0] = 2'b00;
        repeat (901) step();
        evld[0] = 1'b1; edig[0] = 4'd7;
        step();
        evld[0] = 1'b0;
        chk("t1_done", 0, done[0], 2'b01);
        chk("t1_digit", 0, digit[0], 4'd7);
        chk("t1_timeout", 0, tmo[0], 1'b0);
        step();
        chk("t1_idle_grant", 0, grant[0], 2'b00);
        chk("t1_nstart", 0, nstart[0], 1);
        chk("t1_ndone", 0, ndone[0], 1);
        evld[0] = 1'b1; edig[0] = 4'd5;
        repeat (3) step();
        evld[0] = 1'b0;
        chk("t1_spurious_digit", 0, digit[0], 4'd7);
        chk("t1_spurious_busy", 0, busy[0], 1'b0);

        // both requesting, three timed-out jobs
        gseq.delete();
        req[1] = 2'b11;
        n = 0;
        while (gseq.size() < 3 && n < 200) begin step(); n++; end
        req[1] = 2'b00;
        chk("t2_jobs", 1, gseq.size(), 3);
        for (int i = 0; i < 3; i++) chk("t2_grant_seq", i, (i < gseq.size()) ? gseq[i] : 2'b00, exp_seq[i]);
        chk("t2_timeout", 1, tmo[1], 1'b1);
        chk("t2_digit", 1, digit[1], 4'hF);
        chk("t2_latency", 1, t_done[1] - t_start[1], 17);
        n = 0;
        while (busy[1] && n < 40) begin step(); n++; end
        chk("t2_idle", 1, busy[1], 1'b0);

        // valid on the final timeout cycle
        req[1] = 2'b10;
        step();
        req[1] = 2'b00;
        repeat (16) step();
        evld[1] = 1'b1; edig[1] = 4'd3;
        step();
        evld[1] = 1'b0;
        chk("t3_done", 1, done[1], 2'b10);
        chk("t3_digit", 1, digit[1], 4'd3);
        chk("t3_timeout", 1, tmo[1], 1'b0);
        chk("t3_latency", 1, cyc - t_start[1], 17);
        step();

        // canvas snapshot holds while input toggles
        cv0[0] = {30{30'h1C3C0F0F}};
        snap = cv0[0];
        req[0] = 2'b01;
        step();
        req[0] = 2'b00;
        repeat (20) begin cv0[0] = ~cv0[0]; step(); end
        chk_cv("t4_snapshot", 0, ecv[0], snap);
        evld[0] = 1'b1; edig[0] = 4'd9;
        step();
        evld[0] = 1'b0;
        chk("t4_digit", 0, digit[0], 4'd9);
        step();

        // asynchronous reset mid-WAIT
        cv1[0] = {30{30'h01234567}};
        req[0] = 2'b10;
        step();
        req[0] = 2'b00;
        repeat (5) step();
        nd = ndone[0];
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_grant", 0, grant[0], 2'b00);
        chk("t5_start_n", 0, start_n[0], 1'b1);
        chk_cv("t5_canvas", 0, ecv[0], '0);
        chk("t5_done", 0, done[0], 2'b00);
        chk("t5_digit", 0, digit[0], 4'h0);
        chk("t5_timeout", 0, tmo[0], 1'b0);
        chk("t5_busy", 0, busy[0], 1'b0);
        compare();
        step();
        rst_n = 1'b1;
        chk("t5_no_done", 0, ndone[0], nd);
        req[0] = 2'b10;
        step();
        req[0] = 2'b00;
        repeat (3) step();
        evld[0] = 1'b1; edig[0] = 4'd4;
        step();
        evld[0] = 1'b0;
        chk("t5_after_done", 0, done[0], 2'b10);
        chk("t5_after_digit", 0, digit[0], 4'd4);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
